// File: rtl/alu_exec_pkg.sv
`default_nettype none
// ============================================================================
// Module      : alu_exec_pkg
// Description : Shared definitions for the ALU execute stage: opcode
//               encoding, default operand/index widths and the record held
//               in each pipeline stage (E1, E2).
// Revision    : 1.0 - initial release
// ============================================================================
package alu_exec_pkg;

    localparam int c_DATA_W_DEF = 32;
    localparam int c_ADDR_W_DEF = 5;

    typedef enum logic [3:0] {
        OP_ADD   = 4'd0,
        OP_SUB   = 4'd1,
        OP_AND   = 4'd2,
        OP_OR    = 4'd3,
        OP_XOR   = 4'd4,
        OP_SLL   = 4'd5,
        OP_SRL   = 4'd6,
        OP_SRA   = 4'd7,
        OP_SLT   = 4'd8,
        OP_SLTU  = 4'd9,
        OP_PASSB = 4'd10
    } alu_op_e;

    // Stage record. Sized to the package default widths; the execute stage
    // parameters must not exceed these.
    typedef struct packed {
        logic                    valid;
        logic [c_ADDR_W_DEF-1:0] rd;
        logic [c_DATA_W_DEF-1:0] result;
    } stage_rec_t;

endpackage : alu_exec_pkg
`default_nettype wire

// File: rtl/alu_core.sv
`default_nettype none
// ============================================================================
// Module      : alu_core
// Description : Purely combinational ALU datapath. Shift amount is b[4:0];
//               SLT/SLTU yield 0/1; undefined opcodes yield 0. All arithmetic
//               wraps modulo 2^DATA_W.
// Ports       : i_op     - 4-bit opcode (alu_op_e encoding)
//               i_a, i_b - operands
//               o_result - result
// Revision    : 1.0 - initial release
// ============================================================================
module alu_core
    import alu_exec_pkg::*;
#(
    parameter int DATA_W = c_DATA_W_DEF
) (
    input  logic [3:0]        i_op,
    input  logic [DATA_W-1:0] i_a,
    input  logic [DATA_W-1:0] i_b,
    output logic [DATA_W-1:0] o_result
);

    logic [4:0] w_shamt;
    logic       w_lt_s;
    logic       w_lt_u;

    assign w_shamt = i_b[4:0];
    assign w_lt_s  = $signed(i_a) < $signed(i_b);
    assign w_lt_u  = i_a < i_b;

    always_comb begin
        o_result = '0;
        case (i_op)
            OP_ADD:   o_result = i_a + i_b;
            OP_SUB:   o_result = i_a - i_b;
            OP_AND:   o_result = i_a & i_b;
            OP_OR:    o_result = i_a | i_b;
            OP_XOR:   o_result = i_a ^ i_b;
            OP_SLL:   o_result = i_a << w_shamt;
            OP_SRL:   o_result = i_a >> w_shamt;
            OP_SRA:   o_result = $unsigned($signed(i_a) >>> w_shamt);
            OP_SLT:   o_result = {{(DATA_W-1){1'b0}}, w_lt_s};
            OP_SLTU:  o_result = {{(DATA_W-1){1'b0}}, w_lt_u};
            OP_PASSB: o_result = i_b;
            default:  o_result = '0;
        endcase
    end

endmodule : alu_core
`default_nettype wire

// File: rtl/alu_execute_stage.sv
`default_nettype none
// ============================================================================
// Module      : alu_execute_stage
// Description : Two-stage ALU execute pipeline (E1 -> E2) with register-file
//               read/write ports, RAW hazard detection against E1, flush of
//               E1 and a saturating stall counter. E2 never hazards because
//               the register file writes on the falling edge of the cycle in
//               which writeEnable is high.
// Config      : ALU_EXEC_FORWARD_EN - defined: forward the E1 result to
//               matching operands instead of stalling. Undefined (default):
//               deassert in_ready for one cycle on a hazard.
// Ports       : clk, reset (async, active-high)
//               in_valid/in_ready handshake; in_op, in_rs1, in_rs2, in_rd,
//               in_imm, in_use_imm op fields; flush kills the op in E1
//               readReg1/2 -> readData1/2 register-file read
//               writeReg/writeEnable/writeData register-file write
//               stall_count saturating hazard-stall counter
// Revision    : 1.0 - initial release
// ============================================================================
module alu_execute_stage
    import alu_exec_pkg::*;
#(
    parameter int DATA_W = c_DATA_W_DEF,
    parameter int ADDR_W = c_ADDR_W_DEF
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [3:0]        in_op,
    input  logic [ADDR_W-1:0] in_rs1,
    input  logic [ADDR_W-1:0] in_rs2,
    input  logic [ADDR_W-1:0] in_rd,
    input  logic [DATA_W-1:0] in_imm,
    input  logic              in_use_imm,
    input  logic              flush,
    output logic [ADDR_W-1:0] readReg1,
    output logic [ADDR_W-1:0] readReg2,
    input  logic [DATA_W-1:0] readData1,
    input  logic [DATA_W-1:0] readData2,
    output logic [ADDR_W-1:0] writeReg,
    output logic              writeEnable,
    output logic [DATA_W-1:0] writeData,
    output logic [15:0]       stall_count
);

    stage_rec_t        r_e1;
    stage_rec_t        r_e2;
    logic [15:0]       r_stall;

    logic              w_haz_rs1;
    logic              w_haz_rs2;
    logic              w_accept;
    logic [DATA_W-1:0] w_e1_result;
    logic [DATA_W-1:0] w_op_a;
    logic [DATA_W-1:0] w_op_b;
    logic [DATA_W-1:0] w_result;

    assign readReg1 = in_rs1;
    assign readReg2 = in_rs2;

    assign w_e1_result = DATA_W'(r_e1.result);

    // E1 only ever holds valid=1 for rd!=0, so x0 can never hazard.
    assign w_haz_rs1 = r_e1.valid && (r_e1.rd != '0) &&
                       (r_e1.rd == c_ADDR_W_DEF'(in_rs1));
    assign w_haz_rs2 = r_e1.valid && (r_e1.rd != '0) && !in_use_imm &&
                       (r_e1.rd == c_ADDR_W_DEF'(in_rs2));

`ifdef ALU_EXEC_FORWARD_EN
    assign in_ready = !reset && !flush;
    assign w_op_a   = w_haz_rs1 ? w_e1_result : readData1;
    assign w_op_b   = in_use_imm ? in_imm :
                      (w_haz_rs2 ? w_e1_result : readData2);
`else
    // E1 always advances, so a hazard lasts exactly one cycle.
    assign in_ready = !reset && !flush && !w_haz_rs1 && !w_haz_rs2;
    assign w_op_a   = readData1;
    assign w_op_b   = in_use_imm ? in_imm : readData2;
`endif

    assign w_accept = in_valid && in_ready;

    alu_core #(
        .DATA_W (DATA_W)
    ) u_alu_core (
        .i_op     (in_op),
        .i_a      (w_op_a),
        .i_b      (w_op_b),
        .o_result (w_result)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_e1    <= '0;
            r_e2    <= '0;
            r_stall <= '0;
        end else begin
            // Writes to x0 are dropped at entry so they never reach E2.
            r_e1.valid <= w_accept && (in_rd != '0);
            if (w_accept) begin
                r_e1.rd     <= c_ADDR_W_DEF'(in_rd);
                r_e1.result <= c_DATA_W_DEF'(w_result);
            end
            r_e2.valid  <= r_e1.valid && !flush;
            r_e2.rd     <= r_e1.rd;
            r_e2.result <= r_e1.result;
            if (in_valid && !in_ready && (r_stall != 16'hFFFF)) begin
                r_stall <= r_stall + 16'd1;
            end
        end
    end

    assign writeEnable = r_e2.valid;
    assign writeReg    = ADDR_W'(r_e2.rd);
    assign writeData   = DATA_W'(r_e2.result);
    assign stall_count = r_stall;

endmodule : alu_execute_stage
`default_nettype wire

// File: tb/tb_alu_execute_stage.sv
`default_nettype none
// ============================================================================
// Module      : tb_alu_execute_stage
// Description : Directed self-checking bench for alu_execute_stage with a
//               behavioural register file that writes on the falling edge.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_alu_execute_stage;
    import alu_exec_pkg::*;

    logic        clk;
    logic        reset;
    logic        in_valid;
    logic        in_ready;
    logic [3:0]  in_op;
    logic [4:0]  in_rs1, in_rs2, in_rd;
    logic [31:0] in_imm;
    logic        in_use_imm;
    logic        flush;
    logic [4:0]  readReg1, readReg2;
    logic [31:0] readData1, readData2;
    logic [4:0]  writeReg;
    logic        writeEnable;
    logic [31:0] writeData;
    logic [15:0] stall_count;

    logic [31:0] regs [0:31];
    int          n_cmp;
    int          n_fail;

    typedef struct {
        logic [3:0]  op;
        logic [4:0]  rs1;
        logic [4:0]  rs2;
        logic [31:0] imm;
        logic        use_imm;
        logic [31:0] exp;
    } vec_t;
    vec_t tbl [10];

    alu_execute_stage dut (
        .clk         (clk),
        .reset       (reset),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .in_op       (in_op),
        .in_rs1      (in_rs1),
        .in_rs2      (in_rs2),
        .in_rd       (in_rd),
        .in_imm      (in_imm),
        .in_use_imm  (in_use_imm),
        .flush       (flush),
        .readReg1    (readReg1),
        .readReg2    (readReg2),
        .readData1   (readData1),
        .readData2   (readData2),
        .writeReg    (writeReg),
        .writeEnable (writeEnable),
        .writeData   (writeData),
        .stall_count (stall_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    assign readData1 = (readReg1 == 5'd0) ? 32'd0 : regs[readReg1];
    assign readData2 = (readReg2 == 5'd0) ? 32'd0 : regs[readReg2];

    always @(negedge clk) begin
        if (writeEnable) regs[writeReg] = writeData;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic [3:0] op, input logic [4:0] rs1, input logic [4:0] rs2,
                         input logic [4:0] rd, input logic [31:0] imm, input logic use_imm);
        in_valid   = 1'b1;
        in_op      = op;
        in_rs1     = rs1;
        in_rs2     = rs2;
        in_rd      = rd;
        in_imm     = imm;
        in_use_imm = use_imm;
    endtask

    task automatic idle();
        in_valid   = 1'b0;
        in_op      = 4'd0;
        in_rs1     = 5'd0;
        in_rs2     = 5'd0;
        in_rd      = 5'd0;
        in_imm     = 32'd0;
        in_use_imm = 1'b0;
    endtask

    initial begin
        n_cmp  = 0;
        n_fail = 0;
        for (int i = 0; i < 32; i++) regs[i] = 32'd0;
        regs[1] = 32'd5;
        regs[2] = 32'd7;
        regs[4] = 32'h8000_0000;
        reset = 1'b1;
        flush = 1'b0;
        idle();

        // Reset state
        #2;
        chk("rst_we",    {31'd0, writeEnable}, 32'd0);
        chk("rst_wreg",  {27'd0, writeReg},    32'd0);
        chk("rst_wdata", writeData,            32'd0);
        chk("rst_stall", {16'd0, stall_count}, 32'd0);
        chk("rst_ready", {31'd0, in_ready},    32'd0);
        step();
        step();
        reset = 1'b0;
        #1;
        chk("ready_after_rst", {31'd0, in_ready}, 32'd1);

        // ADD x3 = x1 + x2 = 12, two edges after presentation
        drive(OP_ADD, 5'd1, 5'd2, 5'd3, 32'd0, 1'b0);
        #1;
        chk("readReg1", {27'd0, readReg1}, 32'd1);
        chk("readReg2", {27'd0, readReg2}, 32'd2);
        step();
        idle();
        chk("add_lat1_we", {31'd0, writeEnable}, 32'd0);
        step();
        chk("add_we",    {31'd0, writeEnable}, 32'd1);
        chk("add_wreg",  {27'd0, writeReg},    32'd3);
        chk("add_wdata", writeData,            32'd12);
        step();
        chk("add_we_once", {31'd0, writeEnable}, 32'd0);

        // SUB 0-1 then SRA 0x80000000 >>> 4, back to back
        drive(OP_SUB, 5'd0, 5'd0, 5'd7, 32'd1, 1'b1);
        step();
        drive(OP_SRA, 5'd4, 5'd0, 5'd8, 32'd4, 1'b1);
        chk("sra_ready", {31'd0, in_ready}, 32'd1);
        step();
        idle();
        chk("sub_we",    {31'd0, writeEnable}, 32'd1);
        chk("sub_wreg",  {27'd0, writeReg},    32'd7);
        chk("sub_wdata", writeData,            32'hFFFF_FFFF);
        step();
        chk("sra_wreg",  {27'd0, writeReg},    32'd8);
        chk("sra_wdata", writeData,            32'hF800_0000);
        step();
        chk("sra_we_once", {31'd0, writeEnable}, 32'd0);

        // Opcode table, issued one per cycle
        tbl[0] = '{op: OP_AND,   rs1: 5'd1, rs2: 5'd2, imm: 32'd0,          use_imm: 1'b0, exp: 32'd5};
        tbl[1] = '{op: OP_OR,    rs1: 5'd1, rs2: 5'd2, imm: 32'd0,          use_imm: 1'b0, exp: 32'd7};
        tbl[2] = '{op: OP_XOR,   rs1: 5'd1, rs2: 5'd2, imm: 32'd0,          use_imm: 1'b0, exp: 32'd2};
        tbl[3] = '{op: OP_SLL,   rs1: 5'd1, rs2: 5'd0, imm: 32'd3,          use_imm: 1'b1, exp: 32'd40};
        tbl[4] = '{op: OP_SRL,   rs1: 5'd4, rs2: 5'd0, imm: 32'd4,          use_imm: 1'b1, exp: 32'h0800_0000};
        tbl[5] = '{op: OP_SLT,   rs1: 5'd4, rs2: 5'd1, imm: 32'd0,          use_imm: 1'b0, exp: 32'd1};
        tbl[6] = '{op: OP_SLTU,  rs1: 5'd4, rs2: 5'd1, imm: 32'd0,          use_imm: 1'b0, exp: 32'd0};
        tbl[7] = '{op: OP_PASSB, rs1: 5'd1, rs2: 5'd0, imm: 32'hDEAD_BEEF,  use_imm: 1'b1, exp: 32'hDEAD_BEEF};
        tbl[8] = '{op: 4'd12,    rs1: 5'd1, rs2: 5'd2, imm: 32'd0,          use_imm: 1'b0, exp: 32'd0};
        tbl[9] = '{op: OP_SLL,   rs1: 5'd1, rs2: 5'd0, imm: 32'd33,         use_imm: 1'b1, exp: 32'd10};
        for (int i = 0; i <= 10; i++) begin
            if (i < 10) begin
                drive(tbl[i].op, tbl[i].rs1, tbl[i].rs2, 5'(10 + i), tbl[i].imm, tbl[i].use_imm);
                #1;
                chk($sformatf("tbl%0d_ready", i), {31'd0, in_ready}, 32'd1);
            end else begin
                idle();
            end
            step();
            if (i >= 1) begin
                chk($sformatf("tbl%0d_we", i - 1),    {31'd0, writeEnable}, 32'd1);
                chk($sformatf("tbl%0d_wreg", i - 1),  {27'd0, writeReg},    32'(10 + i - 1));
                chk($sformatf("tbl%0d_wdata", i - 1), writeData,            tbl[i - 1].exp);
            end
        end
        idle();
        step();

        // ADDI x5 = x0 + 3, then ADD x6 = x5 + x5
        drive(OP_ADD, 5'd0, 5'd0, 5'd5, 32'd3, 1'b1);
        step();
        drive(OP_ADD, 5'd5, 5'd5, 5'd6, 32'd0, 1'b0);
        #1;
`ifdef ALU_EXEC_FORWARD_EN
        chk("haz_ready_fwd", {31'd0, in_ready}, 32'd1);
        step();
        idle();
        chk("x5_wreg",  {27'd0, writeReg}, 32'd5);
        chk("x5_wdata", writeData,         32'd3);
        chk("haz_stall_fwd", {16'd0, stall_count}, 32'd0);
        step();
`else
        chk("haz_ready_stall", {31'd0, in_ready}, 32'd0);
        step();
        chk("haz_stall_cnt", {16'd0, stall_count}, 32'd1);
        chk("haz_ready_again", {31'd0, in_ready}, 32'd1);
        chk("x5_wreg",  {27'd0, writeReg}, 32'd5);
        chk("x5_wdata", writeData,         32'd3);
        step();
        idle();
        chk("haz_bubble_we", {31'd0, writeEnable}, 32'd0);
        step();
`endif
        chk("x6_we",    {31'd0, writeEnable}, 32'd1);
        chk("x6_wreg",  {27'd0, writeReg},    32'd6);
        chk("x6_wdata", writeData,            32'd6);
        step();

        // rd = 0: never written, and a following read of x0 is not stalled
        drive(OP_ADD, 5'd1, 5'd2, 5'd0, 32'd0, 1'b0);
        step();
        drive(OP_ADD, 5'd0, 5'd0, 5'd9, 32'd0, 1'b0);
        #1;
        chk("x0_no_stall", {31'd0, in_ready}, 32'd1);
        step();
        idle();
        chk("x0_we", {31'd0, writeEnable}, 32'd0);
        step();
        chk("x9_we",    {31'd0, writeEnable}, 32'd1);
        chk("x9_wreg",  {27'd0, writeReg},    32'd9);
        chk("x9_wdata", writeData,            32'd0);
        step();

        // Flush with A in E2 and B in E1
        drive(OP_ADD, 5'd1, 5'd2, 5'd20, 32'd0, 1'b0);
        step();
        drive(OP_ADD, 5'd1, 5'd1, 5'd21, 32'd0, 1'b0);
        step();
        drive(OP_ADD, 5'd2, 5'd2, 5'd22, 32'd0, 1'b0);
        flush = 1'b1;
        #1;
        chk("flush_ready", {31'd0, in_ready},    32'd0);
        chk("flush_a_we",  {31'd0, writeEnable}, 32'd1);
        chk("flush_a_wreg", {27'd0, writeReg},   32'd20);
        chk("flush_a_wdata", writeData,          32'd12);
        step();
        flush = 1'b0;
        idle();
        chk("flush_b_killed", {31'd0, writeEnable}, 32'd0);
`ifdef ALU_EXEC_FORWARD_EN
        chk("flush_stall", {16'd0, stall_count}, 32'd1);
`else
        chk("flush_stall", {16'd0, stall_count}, 32'd2);
`endif
        step();
        chk("flush_c_dropped", {31'd0, writeEnable}, 32'd0);
        step();

        // Reset between accept and writeback
        drive(OP_ADD, 5'd1, 5'd2, 5'd23, 32'd0, 1'b0);
        step();
        drive(OP_ADD, 5'd1, 5'd1, 5'd24, 32'd0, 1'b0);
        step();
        idle();
        chk("pre_rst_we", {31'd0, writeEnable}, 32'd1);
        #2;
        reset = 1'b1;
        #1;
        chk("mid_rst_we",    {31'd0, writeEnable}, 32'd0);
        chk("mid_rst_wreg",  {27'd0, writeReg},    32'd0);
        chk("mid_rst_wdata", writeData,            32'd0);
        chk("mid_rst_stall", {16'd0, stall_count}, 32'd0);
        chk("mid_rst_ready", {31'd0, in_ready},    32'd0);
        step();
        reset = 1'b0;
        for (int k = 0; k < 3; k++) begin
            step();
            chk($sformatf("post_rst_we%0d", k), {31'd0, writeEnable}, 32'd0);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule : tb_alu_execute_stage
`default_nettype wire

// File: doc/alu_execute_stage.md
ALU_EXECUTE_STAGE -- requirements
Module: alu_execute_stage

Interface
REQ-001 SHALL have parameter DATA_W, default 32, meaning operand/result width.
REQ-002 SHALL have parameter ADDR_W, default 5, meaning register index width.
REQ-003 SHALL have one clock and one reset: reset is asynchronous and active-high.
REQ-004 clk  in  1  rising-edge clock for all state.
REQ-005 reset  in  1  asynchronous active-high reset.
REQ-006 in_valid  in  1  upstream op valid.
REQ-007 in_ready  out  1  stage accepts op this cycle.
REQ-008 in_op  in  4  ALU opcode, from package enum.
REQ-009 in_rs1, in_rs2  in  ADDR_W  source register indices.
REQ-010 in_rd  in  ADDR_W  destination register index.
REQ-011 in_imm  in  DATA_W  immediate.
REQ-012 in_use_imm  in  1  operand B = in_imm instead of readData2.
REQ-013 flush  in  1  kill op held in E1.
REQ-014 readReg1, readReg2  out  ADDR_W  register-file read indices.
REQ-015 readData1, readData2  in  DATA_W  register-file read data.
REQ-016 writeReg  out  ADDR_W  register-file write index.
REQ-017 writeEnable  out  1  register-file write strobe.
REQ-018 writeData  out  DATA_W  register-file write data.
REQ-019 stall_count  out  16  saturating hazard-stall cycle counter.

Function
REQ-020 readReg1/readReg2 SHALL equal in_rs1/in_rs2 combinationally.
REQ-021 An op SHALL be accepted on a rising edge when in_valid && in_ready.
REQ-022 Pipeline: E1 SHALL register {valid, rd, result} at the accept edge; E2 SHALL register the E1 contents one edge later and drive writeReg/writeData/writeEnable.
REQ-023 Latency SHALL be 2: writeEnable is high in the cycle after the second edge following accept, for exactly one cycle per op.
REQ-024 The register file writes on the falling edge of that cycle, so E2 SHALL NOT create a hazard.
REQ-025 Ops: ADD=0, SUB=1, AND=2, OR=3, XOR=4, SLL=5, SRL=6, SRA=7, SLT=8 (signed), SLTU=9, PASSB=10.
- Shift amount = B[4:0].
- SLT/SLTU yield 0 or 1.
- Opcodes 11..15 yield result 0 and are still written.
REQ-026 Arithmetic SHALL wrap modulo 2^DATA_W; no flags.
REQ-027 in_rd==0 SHALL never assert writeEnable and SHALL never cause a hazard.
REQ-028 Hazard SHALL exist when E1 is valid, E1.rd!=0, and E1.rd equals in_rs1, or equals in_rs2 with in_use_imm==0.
REQ-029 flush SHALL invalidate E1 at the next edge and block acceptance in that cycle; E2 SHALL complete normally.
REQ-030 stall_count SHALL increment on each edge where in_valid && !in_ready && !reset, and saturate at 16'hFFFF.
REQ-031 Accepting an op with E1 empty, or with E1 advancing, SHALL be allowed every cycle (throughput 1/cycle absent hazards).

Reset
REQ-032 Reset SHALL clear E1/E2 valid, writeEnable=0, writeReg=0, writeData=0, stall_count=0, immediately and independent of clk.
REQ-033 in_ready SHALL be 0 while reset is high.
REQ-034 Reset mid-operation SHALL discard in-flight ops with no write issued.

Configuration
REQ-035 Macro ALU_EXEC_FORWARD_EN defined: on hazard, the E1 result SHALL be forwarded to the matching operand(s) and in_ready stays 1 (no stall).
REQ-036 Macro ALU_EXEC_FORWARD_EN undefined: on hazard, in_ready SHALL be 0 for one cycle, until the hazard op leaves E1.

Structure
REQ-037 Package alu_exec_pkg SHALL hold the opcode enum, DATA_W/ADDR_W defaults and the E1/E2 stage-record typedef.
REQ-038 Sub-module alu_core SHALL be purely combinational (op, a, b -> result) and instantiated once.

Verification
REQ-039 Reset, then ADD rs1=1(5), rs2=2(7), rd=3 -> two edges later writeEnable=1, writeReg=3, writeData=12, for one cycle.
REQ-040 SUB with a=0, b=1, then SRA a=32'h80000000 by 4 -> writeData 32'hFFFFFFFF, then 32'hF8000000.
REQ-041 Back-to-back ops: ADDI x5=x0+3, then ADD x6=x5+x5:
- with FORWARD_EN -> no stall, x6=6.
- without FORWARD_EN -> in_ready low one cycle, stall_count=1, x6=6.
REQ-042 Op with rd=0 -> writeEnable stays 0; a following op reading x0 is not stalled.
REQ-043 flush asserted with an op in E1 -> that op is never written; the older E2 op is still written.
REQ-044 Reset asserted between accept and writeback -> outputs zero immediately; no write occurs after release.
